aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Multi-slot AES key-schedule engine for 128/192/256-bit keys; one 32-bit w[i] word per clk.
//  Stores SLOTS independent expanded schedules in a word RAM.
//  A registered read port returns any round key, in forward or reversed (decrypt) order.
//  Feeds the cipher/inverse-cipher round datapaths; supports key pre-loading while another slot is in use.
// PARAMETERS
//  SLOTS    2  number of independently stored expanded schedules (>=1)
//  SLOT_W   1  width of slot index, = max(1,clog2(SLOTS))
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  start      in   1        request expansion of key_in into slot wr_slot (sampled in IDLE only)
//  nk         in   4        key length in words: 4, 6 or 8; anything else is an error
//  key_in     in   256      key; key_in[255:224]=w[0]; Nk=4 uses [255:128], Nk=6 uses [255:64]
//  wr_slot    in   SLOT_W   target slot, captured with start
//  busy       out  1        expansion in progress
//  done       out  1        one-cycle pulse: slot fully expanded
//  err        out  1        one-cycle pulse: start rejected (bad nk or wr_slot>=SLOTS)
//  slot_valid out  SLOTS    bit s = slot s holds a complete schedule
//  rd_req     in   1        read request
//  rd_slot    in   SLOT_W   slot to read
//  rd_round   in   4        round index 0..Nr of that slot
//  rd_inv     in   1        1: return round (Nr - rd_round) instead of rd_round
//  rd_key     out  128      round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//  rd_valid   out  1        rd_key is valid
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, rd_valid=0; slot_valid=0; rd_key=0; RAM not cleared.
//  FSM: IDLE -> LOAD -> EXPAND -> IDLE.
//   IDLE + start + legal: latch nk, wr_slot, key; clear slot_valid[wr_slot]; go to LOAD.
//   IDLE + start + illegal: err=1 for one cycle; stay IDLE; slot_valid unchanged.
//   start outside IDLE is ignored (no err, no queueing).
//  LOAD (1 cycle): write w[0..Nk-1] to the slot.
//  EXPAND: i = Nk .. 4*(Nr+1)-1, one word per cycle; Nr = Nk+6.
//   temp = w[i-1].
//   i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ Rcon(i/Nk).
//   Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
//   w[i] = w[i-Nk] ^ temp.
//   Keep w[i-Nk..i-1] in an 8-word shift window; never read them back from the RAM.
//  Rcon: 8-bit register, starts at 01, xtime'd after each use (01,02,..,80,1b,36); no table.
//  Cycle count start -> done: 1 + (44-4)=41 / 1 + (52-6)=47 / 1 + (60-8)=53 cycles for Nk=4/6/8.
//   done pulses the cycle after the last word is written.
//   slot_valid[slot] is set in the same cycle; busy drops in the same cycle.
//  Per-slot nk is stored so reads of that slot use its own Nr.
//  Read (1-cycle latency): request at cycle t -> rd_key/rd_valid at t+1, using the slot_valid/Nr of cycle t.
//   rd_valid=0 and rd_key=0 if: slot invalid, being expanded, rd_slot>=SLOTS, or rd_round>Nr.
//   rd_req=0 -> rd_valid=0 next cycle; rd_key holds its previous value.
//   Reads of other slots proceed at full rate during EXPAND.
//  Simultaneous done and read of the same slot: the read returns rd_valid=0; the next cycle's read is valid.
//  rst mid-expansion: aborts at once; all slot_valid cleared; no done pulse.
// TESTING
//  Nk=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
//   done exactly 41 cycles after start.
//   Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//   rd_inv=1, round 0 returns the same value.
//  Nk=6, key 8e73b0f7..522c6b7b (FIPS-197 A.2): 47 cycles; round 12 low word = 01002202.
//  Nk=8, key 603deb10..0914dff4 (FIPS-197 A.3) into slot 1 while slot 0 holds the A.1 schedule:
//   Slot 0 reads stay correct during expansion.
//   Slot 1 round 14 low word = 706c631e after 53 cycles.
//  nk=5 and nk=9 -> err pulse, busy stays 0, slot_valid unchanged. Also: start while busy ignored.
//  rd_round=11 on a Nk=4 slot -> rd_valid=0.
//  Read of the slot under expansion -> rd_valid=0 until the cycle after done.
//  rst asserted at word 20 of an Nk=8 expansion:
//   busy=0 and slot_valid=0 the next cycle; no done pulse.
//   A new start then completes normally.

Source files
------------

// File: rtl/aes_key_schedule.sv
// Multi-slot AES-128/192/256 key expansion, one w[i] word per clock,
// with a registered round-key read port (forward or reversed order).
module aes_key_schedule #(
  parameter int SLOTS  = 2,
  parameter int SLOT_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        nk,
  input  logic [255:0]      key_in,
  input  logic [SLOT_W-1:0] wr_slot,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SLOTS-1:0]  slot_valid,
  input  logic              rd_req,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [3:0]        rd_round,
  input  logic              rd_inv,
  output logic [127:0]      rd_key,
  output logic              rd_valid
);

  localparam int DEPTH = SLOTS * 60;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
  state_t state, state_nx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, bb;
    p  = '0;
    x  = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ x;
      x  = xtime(x);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
    return int'(s) < SLOTS;
  endfunction

  logic [31:0]       ram [DEPTH];
  logic [31:0]       win [8];
  logic [31:0]       kw  [8];
  logic [3:0]        slot_nk [SLOTS];
  logic [3:0]        nk_q;
  logic [SLOT_W-1:0] slot_q;
  logic [5:0]        i_q;
  logic [2:0]        m_q;
  logic [7:0]        rcon_q;
  logic [31:0]       temp, old, new_w;
  logic              legal, last_w;
  logic              rd_ok;
  logic [AW-1:0]     rd_addr;
  int                rd_nr, rd_r;

  assign legal  = (nk == 4'd4 || nk == 4'd6 || nk == 4'd8) && slot_ok(wr_slot);
  assign last_w = (i_q == {nk_q, 2'b00} + 6'd27);
  assign busy   = (state != IDLE);

  always_comb begin
    for (int k = 0; k < 8; k++) kw[k] = key_in[255-32*k -: 32];
  end

  // win[0] = w[i-1], win[Nk-1] = w[i-Nk]
  always_comb begin
    temp = win[0];
    if (m_q == 3'd0)
      temp = sub_word({win[0][23:0], win[0][31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && m_q == 3'd4)
      temp = sub_word(win[0]);
    unique case (1'b1)
      nk_q == 4'd4: old = win[3];
      nk_q == 4'd6: old = win[5];
      default:      old = win[7];
    endcase
    new_w = old ^ temp;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && legal) state_nx = LOAD;
      LOAD:    state_nx = EXPAND;
      EXPAND:  if (last_w) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      err        <= 1'b0;
      slot_valid <= '0;
      nk_q       <= '0;
      slot_q     <= '0;
      i_q        <= '0;
      m_q        <= '0;
      rcon_q     <= 8'h01;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          if (legal) begin
            nk_q                <= nk;
            slot_q              <= wr_slot;
            slot_valid[wr_slot] <= 1'b0;
          end else begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          i_q    <= {2'b00, nk_q};
          m_q    <= 3'd0;
          rcon_q <= 8'h01;
        end
        EXPAND: begin
          i_q <= i_q + 6'd1;
          m_q <= ({1'b0, m_q} + 4'd1 == nk_q) ? 3'd0 : m_q + 3'd1;
          if (m_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (last_w) begin
            done               <= 1'b1;
            slot_valid[slot_q] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage: schedule words, the sliding window and per-slot key length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && start && legal) begin
        slot_nk[wr_slot] <= nk;
        for (int k = 0; k < 8; k++) begin
          win[k] <= '0;
          if (k < int'(nk)) win[k] <= kw[3'(int'(nk) - 1 - k)];
        end
      end
      if (state == LOAD) begin
        for (int k = 0; k < 8; k++)
          if (k < int'(nk_q))
            ram[AW'(int'(slot_q) * 60 + k)] <= win[3'(int'(nk_q) - 1 - k)];
      end
      if (state == EXPAND) begin
        ram[AW'(int'(slot_q) * 60 + int'(i_q))] <= new_w;
        win[0] <= new_w;
        for (int k = 1; k < 8; k++) win[k] <= win[k-1];
      end
    end
  end

  always_comb begin
    rd_ok   = 1'b0;
    rd_addr = '0;
    rd_nr   = 0;
    rd_r    = 0;
    if (slot_ok(rd_slot)) begin
      rd_nr = int'(slot_nk[rd_slot]) + 6;
      if (slot_valid[rd_slot] && int'(rd_round) <= rd_nr) begin
        rd_ok   = 1'b1;
        rd_r    = rd_inv ? rd_nr - int'(rd_round) : int'(rd_round);
        rd_addr = AW'(int'(rd_slot) * 60 + 4 * rd_r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_req) begin
        rd_valid <= rd_ok;
        rd_key   <= rd_ok ? {ram[rd_addr], ram[rd_addr + AW'(1)],
                             ram[rd_addr + AW'(2)], ram[rd_addr + AW'(3)]}
                          : '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 known answers, read table,
// corner sequences and random keys against a reference expansion.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, rd_req, rd_inv;
  logic [3:0]   nk, rd_round;
  logic [255:0] key_in;
  logic [0:0]   wr_slot, rd_slot;
  logic         busy, done, err, rd_valid;
  logic [1:0]   slot_valid;
  logic [127:0] rd_key;

  aes_key_schedule #(.SLOTS(2), .SLOT_W(1)) dut (
    .clk(clk), .rst(rst), .start(start), .nk(nk), .key_in(key_in),
    .wr_slot(wr_slot), .busy(busy), .done(done), .err(err),
    .slot_valid(slot_valid), .rd_req(rd_req), .rd_slot(rd_slot),
    .rd_round(rd_round), .rd_inv(rd_inv), .rd_key(rd_key),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [2][60];
  int          mnk [2];

  localparam logic [255:0] K1 =
    256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K2 =
    256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_0000000000000000;
  localparam logic [255:0] K3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           slot;
    int           round;
    bit           inv;
    bit           ev;
    logic [127:0] ek;
  } rv_t;
  rv_t tbl [$];

  task automatic check(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic int gm(input int a, input int b);
    int p = 0;
    for (int k = 0; k < 8; k++) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 256) != 0) a = a ^ 283;
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] c, inv, b;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (a != 0 && gm(a, y) == 1) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = b;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input int s, input int n, input logic [255:0] k);
    logic [31:0] t;
    int r;
    mnk[s] = n;
    for (int i = 0; i < n; i++) mw[s][i] = k[255-32*i -: 32];
    for (int i = n; i < 4 * (n + 7); i++) begin
      t = mw[s][i-1];
      if (i % n == 0) begin
        r = 1;
        for (int j = 1; j < i / n; j++) r = gm(r, 2);
        t = subw({t[23:0], t[31:24]}) ^ (32'(r) << 24);
      end else if (n == 8 && i % n == 4) begin
        t = subw(t);
      end
      mw[s][i] = mw[s][i-n] ^ t;
    end
  endtask

  function automatic logic [127:0] mkey(input int s, input int r);
    return {mw[s][4*r], mw[s][4*r+1], mw[s][4*r+2], mw[s][4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int n, input logic [255:0] k, input int s);
    nk      = n[3:0];
    key_in  = k;
    wr_slot = s[0];
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 200) begin
      tick();
      c++;
    end
  endtask

  task automatic do_read(input int s, input int r, input bit inv);
    rd_req   = 1'b1;
    rd_slot  = s[0];
    rd_round = r[3:0];
    rd_inv   = inv;
    tick();
    rd_req   = 1'b0;
  endtask

  initial begin
    int c, c2, n, s, r, dcnt;
    bit inv;
    logic [255:0] k;
    logic [127:0] held;

    rst = 1'b1; start = 1'b0; rd_req = 1'b0; rd_inv = 1'b0;
    nk = '0; rd_round = '0; key_in = '0; wr_slot = '0; rd_slot = '0;
    build_sbox();
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_sv", 128'(slot_valid), 128'(0));
    check("rst_rdv", 128'(rd_valid), 128'(0));
    check("rst_rdkey", rd_key, 128'(0));

    // AES-128 into slot 0
    model_expand(0, 4, K1);
    kick(4, K1, 0);
    check("a1_busy", 128'(busy), 128'(1));
    wait_done(c);
    check("a1_cycles", 128'(c), 128'(41));
    check("a1_busy_off", 128'(busy), 128'(0));
    check("a1_sv", 128'(slot_valid), 128'(2'b01));
    tick();
    check("a1_done_pulse", 128'(done), 128'(0));

    tbl.push_back('{0, 10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    tbl.push_back('{0, 0, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    tbl.push_back('{0, 0, 1'b0, 1'b1, K1[255:128]});
    tbl.push_back('{0, 10, 1'b1, 1'b1, K1[255:128]});
    tbl.push_back('{0, 1, 1'b0, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605});
    tbl.push_back('{0, 5, 1'b0, 1'b1, mkey(0, 5)});
    tbl.push_back('{0, 3, 1'b1, 1'b1, mkey(0, 7)});
    tbl.push_back('{0, 11, 1'b0, 1'b0, 128'h0});
    tbl.push_back('{0, 15, 1'b1, 1'b0, 128'h0});
    tbl.push_back('{1, 0, 1'b0, 1'b0, 128'h0});
    foreach (tbl[i]) begin
      do_read(tbl[i].slot, tbl[i].round, tbl[i].inv);
      check($sformatf("tbl%0d_valid", i), 128'(rd_valid), 128'(tbl[i].ev));
      check($sformatf("tbl%0d_key", i), rd_key, tbl[i].ek);
    end

    do_read(0, 2, 1'b0);
    held = rd_key;
    check("hold_pre", held, mkey(0, 2));
    tick();
    check("hold_valid", 128'(rd_valid), 128'(0));
    check("hold_key", rd_key, mkey(0, 2));

    // AES-192 into slot 1
    model_expand(1, 6, K2);
    kick(6, K2, 1);
    wait_done(c);
    check("a2_cycles", 128'(c), 128'(47));
    do_read(1, 12, 1'b0);
    check("a2_r12_low", 128'(rd_key[31:0]), 128'(32'h01002202));
    for (int i = 0; i <= 12; i++) begin
      do_read(1, i, 1'b0);
      check($sformatf("a2_r%0d", i), rd_key, mkey(1, i));
    end

    // AES-256 into slot 1 while slot 0 is being read
    model_expand(1, 8, K3);
    kick(8, K3, 1);
    c = 0;
    while (!done && c < 200) begin
      s = c % 2;
      r = c % 11;
      do_read(s, r, 1'b0);
      c++;
      check($sformatf("a3_bg%0d_v", c), 128'(rd_valid), 128'(s == 0));
      check($sformatf("a3_bg%0d_k", c), rd_key, s == 0 ? mkey(0, r) : 128'(0));
    end
    check("a3_cycles", 128'(c), 128'(53));
    do_read(1, 14, 1'b0);
    check("a3_after_done_v", 128'(rd_valid), 128'(1));
    check("a3_r14_low", 128'(rd_key[31:0]), 128'(32'h706c631e));
    check("a3_r14", rd_key, mkey(1, 14));
    do_read(1, 14, 1'b1);
    check("a3_inv14", rd_key, K3[255:128]);

    // Rejected starts
    kick(5, K1, 0);
    check("nk5_err", 128'(err), 128'(1));
    check("nk5_busy", 128'(busy), 128'(0));
    check("nk5_sv", 128'(slot_valid), 128'(2'b11));
    tick();
    check("nk5_err_pulse", 128'(err), 128'(0));
    kick(9, K1, 1);
    check("nk9_err", 128'(err), 128'(1));
    check("nk9_busy", 128'(busy), 128'(0));
    check("nk9_sv", 128'(slot_valid), 128'(2'b11));

    // Start while busy is ignored
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    model_expand(0, 4, k);
    kick(4, k, 0);
    tick(); tick(); tick();
    kick(8, K2, 1);
    check("busy_start_err", 128'(err), 128'(0));
    wait_done(c2);
    check("busy_start_cycles", 128'(c2 + 4), 128'(41));
    check("busy_start_sv", 128'(slot_valid), 128'(2'b11));
    do_read(1, 14, 1'b0);
    check("busy_start_s1", rd_key, mkey(1, 14));
    do_read(0, 10, 1'b0);
    check("busy_start_s0", rd_key, mkey(0, 10));

    // Reset at word 20 of an AES-256 expansion
    kick(8, {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom}, 1);
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_sv", 128'(slot_valid), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("abort_no_done", 128'(dcnt), 128'(0));
    do_read(0, 0, 1'b0);
    check("abort_rd", 128'(rd_valid), 128'(0));
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0};
    model_expand(0, 6, k);
    kick(6, k, 0);
    wait_done(c);
    check("post_abort_cycles", 128'(c), 128'(47));
    check("post_abort_sv", 128'(slot_valid), 128'(2'b01));
    for (int i = 0; i <= 12; i++) begin
      do_read(0, i, 1'b1);
      check($sformatf("post_abort_inv%0d", i), rd_key, mkey(0, 12 - i));
    end

    // Random keys, lengths and slots
    for (int t = 0; t < 4; t++) begin
      case ($urandom_range(0, 2))
        0:       n = 4;
        1:       n = 6;
        default: n = 8;
      endcase
      s = int'($urandom_range(0, 1));
      k = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      model_expand(s, n, k);
      kick(n, k, s);
      wait_done(c);
      check($sformatf("rnd%0d_cycles", t), 128'(c), 128'(1 + 3 * n + 28));
      for (int i = 0; i <= n + 7; i++) begin
        inv = 1'($urandom_range(0, 1));
        do_read(s, i, inv);
        check($sformatf("rnd%0d_r%0d_v", t, i), 128'(rd_valid), 128'(i <= n + 6));
        check($sformatf("rnd%0d_r%0d_k", t, i), rd_key,
              i > n + 6 ? 128'(0) : mkey(s, inv ? n + 6 - i : i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
